mode_control_sequencer: RTL

- Parametrised successor to the single-bit mode-control PIO: an Avalon-MM slave driving a WIDTH-bit mode output bus with break-before-make sequencing.
- Bits turning off drop immediately. Bits turning on are held off for a programmable dead-time so pumps, valves and heaters never overlap during mode changes.
- Adds set/clear aliases, a status register, a sticky change-done event with interrupt, and registered reads.
- Sits between the HPS/Nios bridge and the actuator driver logic.

---
 rtl/mode_control_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mode_control_sequencer.sv
// Avalon-MM mode output register with break-before-make sequencing: bits turning
// off drop at once, bits turning on wait a programmable dead-time.
module mode_control_sequencer #(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      DT_BITS     = 16,
    parameter int unsigned      DT_DEFAULT  = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_STATUS   = 3'd1;
    localparam logic [2:0] ADDR_DEADTIME = 3'd2;
    localparam logic [2:0] ADDR_OUTSET   = 3'd3;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd4;
    localparam logic [2:0] ADDR_EVENT    = 3'd5;

    typedef enum logic {IDLE, BREAK} state_t;

    state_t             state;
    logic [WIDTH-1:0]   target;
    logic [DT_BITS-1:0] deadtime;
    logic [DT_BITS-1:0] counter;
    logic               done_evt;
    logic               irq_en;

    logic               wr_c;
    logic               rd_c;
    logic               target_wr_c;
    logic               dt_zero_c;
    logic               evt_clr_c;
    logic [WIDTH-1:0]   new_target_c;
    logic [WIDTH-1:0]   newly_on_c;
    logic [31:0]        read_mux_c;
    state_t             state_n_c;
    logic [WIDTH-1:0]   out_n_c;
    logic [DT_BITS-1:0] counter_n_c;
    logic               done_set_c;
    logic               done_n_c;
    logic               irq_en_n_c;
    logic               unused_wd_c;

    // Bus decode and the target value the sequencer sees on this edge.
    always_comb begin
        wr_c         = chipselect && !write_n;
        rd_c         = chipselect && write_n;
        target_wr_c  = 1'b0;
        new_target_c = target;
        if (wr_c) begin
            case (address)
                ADDR_DATA: begin
                    new_target_c = writedata[WIDTH-1:0];
                    target_wr_c  = 1'b1;
                end
                ADDR_OUTSET: begin
                    new_target_c = target | writedata[WIDTH-1:0];
                    target_wr_c  = 1'b1;
                end
                ADDR_OUTCLEAR: begin
                    new_target_c = target & ~writedata[WIDTH-1:0];
                    target_wr_c  = 1'b1;
                end
                default: ;
            endcase
        end
        newly_on_c  = new_target_c & ~out_port;
        dt_zero_c   = (deadtime == '0);
        evt_clr_c   = wr_c && (address == ADDR_EVENT) && writedata[0];
        unused_wd_c = ^writedata;
    end

    // Sequencer next state: newly-on bits wait out the dead-time, cleared bits drop now.
    always_comb begin
        state_n_c   = state;
        out_n_c     = out_port;
        counter_n_c = counter;
        done_set_c  = 1'b0;
        case (state)
            IDLE: begin
                if (new_target_c != out_port) begin
                    if ((newly_on_c != '0) && !dt_zero_c) begin
                        out_n_c     = out_port & new_target_c;
                        counter_n_c = deadtime - DT_BITS'(1);
                        state_n_c   = BREAK;
                    end else begin
                        out_n_c    = new_target_c;
                        done_set_c = 1'b1;
                    end
                end
            end
            BREAK: begin
                out_n_c = out_port & new_target_c;
                if (target_wr_c && (newly_on_c != '0) && !dt_zero_c) begin
                    counter_n_c = deadtime - DT_BITS'(1);
                end else if (target_wr_c || (counter == '0)) begin
                    out_n_c    = new_target_c;
                    done_set_c = 1'b1;
                    state_n_c  = IDLE;
                end else begin
                    counter_n_c = counter - DT_BITS'(1);
                end
            end
            default: state_n_c = IDLE;
        endcase
        done_n_c   = done_set_c | (done_evt & ~evt_clr_c);
        irq_en_n_c = (wr_c && (address == ADDR_EVENT)) ? writedata[8] : irq_en;
    end

    // Register read mux; unused bits and addresses read as zero.
    always_comb begin
        read_mux_c = '0;
        case (address)
            ADDR_DATA:     read_mux_c = 32'(out_port);
            ADDR_STATUS:   read_mux_c = {29'd0, done_evt, (target != out_port), (state == BREAK)};
            ADDR_DEADTIME: read_mux_c = 32'(deadtime);
            ADDR_OUTSET:   read_mux_c = 32'(target);
            ADDR_OUTCLEAR: read_mux_c = 32'(target);
            ADDR_EVENT:    read_mux_c = {23'd0, irq_en, 7'd0, done_evt};
            default:       read_mux_c = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            target   <= RESET_VALUE;
            out_port <= RESET_VALUE;
            deadtime <= DT_BITS'(DT_DEFAULT);
            counter  <= '0;
            done_evt <= 1'b0;
            irq_en   <= 1'b0;
            irq      <= 1'b0;
            readdata <= '0;
        end else begin
            state    <= state_n_c;
            target   <= new_target_c;
            out_port <= out_n_c;
            counter  <= counter_n_c;
            done_evt <= done_n_c;
            irq_en   <= irq_en_n_c;
            irq      <= done_n_c & irq_en_n_c;
            if (wr_c && (address == ADDR_DEADTIME)) begin
                deadtime <= writedata[DT_BITS-1:0];
            end
            if (rd_c) begin
                readdata <= read_mux_c;
            end
        end
    end

endmodule
